// File: rtl/mem_read_arbiter.sv
// Two-requester round-robin arbiter sharing one AR/R memory read port, one read in flight.
// Define MEM_READ_ARB_TIMEOUT_EN to add the read-data watchdog (TIMEOUT_CYCLES) and timeout_err.
module mem_read_arbiter #(
    parameter int ADDR_WDTH      = 4,
    parameter int DATA_WDTH      = 32,
    parameter int RESP_WDTH      = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_ar_valid,
    input  logic [ADDR_WDTH-1:0] m0_ar_address,
    output logic                 m0_ar_ready,
    output logic                 m0_r_valid,
    output logic [DATA_WDTH-1:0] m0_r_data,
    output logic [RESP_WDTH-1:0] m0_r_resp,
    input  logic                 m0_r_ready,
    input  logic                 m1_ar_valid,
    input  logic [ADDR_WDTH-1:0] m1_ar_address,
    output logic                 m1_ar_ready,
    output logic                 m1_r_valid,
    output logic [DATA_WDTH-1:0] m1_r_data,
    output logic [RESP_WDTH-1:0] m1_r_resp,
    input  logic                 m1_r_ready,
    output logic                 s_ar_valid,
    output logic [ADDR_WDTH-1:0] s_ar_address,
    input  logic                 s_ar_ready,
    input  logic                 s_r_valid,
    input  logic [DATA_WDTH-1:0] s_r_data,
    input  logic [RESP_WDTH-1:0] s_r_resp,
    output logic                 s_r_ready,
    output logic [1:0]           gnt,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic                 owner_s;
    logic                 own_ar_valid_s;
    logic [ADDR_WDTH-1:0] own_ar_address_s;
    logic                 own_r_ready_s;
    logic                 own_r_valid_s;
    logic [DATA_WDTH-1:0] own_r_data_s;
    logic [RESP_WDTH-1:0] own_r_resp_s;
    logic                 timed_out_s;
    logic                 drain_s;

    assign owner_s = gnt_q[1];
    assign gnt     = gnt_q;

    // Owner-side request signals selected by the registered grant.
    always_comb begin
        if (owner_s) begin
            own_ar_valid_s   = m1_ar_valid;
            own_ar_address_s = m1_ar_address;
            own_r_ready_s    = m1_r_ready;
        end else begin
            own_ar_valid_s   = m0_ar_valid;
            own_ar_address_s = m0_ar_address;
            own_r_ready_s    = m0_r_ready;
        end
    end

`ifdef MEM_READ_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;

    assign timed_out_s = (state_q == ST_DATA) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign drain_s     = timeout_err_q;
    assign timeout_err = timeout_err_q;

    // Watchdog next state; held at zero in ADDR so every DATA phase starts counting from zero.
    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == ST_ADDR) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == ST_DATA) && !s_r_valid && !timed_out_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (timed_out_s && own_r_ready_s) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= {CNT_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    logic unused_timeout_s;

    assign timed_out_s      = 1'b0;
    assign drain_s          = 1'b0;
    assign timeout_err      = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 32'sd0);
`endif

    // Arbitration and transaction sequencing; a tie goes to the requester that was not last served.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_ar_valid && m1_ar_valid) begin
                    state_d = ST_ADDR;
                    gnt_d   = last_q ? 2'b01 : 2'b10;
                end else if (m0_ar_valid) begin
                    state_d = ST_ADDR;
                    gnt_d   = 2'b01;
                end else if (m1_ar_valid) begin
                    state_d = ST_ADDR;
                    gnt_d   = 2'b10;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                end
            end
            ST_ADDR: begin
                if (!own_ar_valid_s) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                end else if (s_ar_ready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if ((timed_out_s || s_r_valid) && own_r_ready_s) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = owner_s;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Memory-side outputs and the owner's response beat; a timed-out read returns a synthetic error beat.
    always_comb begin
        s_ar_valid    = 1'b0;
        s_ar_address  = {ADDR_WDTH{1'b0}};
        s_r_ready     = 1'b0;
        m0_ar_ready   = 1'b0;
        m1_ar_ready   = 1'b0;
        own_r_valid_s = 1'b0;
        own_r_data_s  = {DATA_WDTH{1'b0}};
        own_r_resp_s  = {RESP_WDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                s_r_ready = drain_s;
            end
            ST_ADDR: begin
                s_ar_valid   = own_ar_valid_s;
                s_ar_address = own_ar_address_s;
                if (owner_s) begin
                    m1_ar_ready = s_ar_ready;
                end else begin
                    m0_ar_ready = s_ar_ready;
                end
            end
            ST_DATA: begin
                if (timed_out_s) begin
                    own_r_valid_s = 1'b1;
                    own_r_resp_s  = {RESP_WDTH{1'b1}};
                end else begin
                    own_r_valid_s = s_r_valid;
                    own_r_data_s  = s_r_data;
                    own_r_resp_s  = s_r_resp;
                    s_r_ready     = own_r_ready_s;
                end
            end
            default: begin
                s_r_ready = 1'b0;
            end
        endcase
    end

    // Response routing: the non-owner always sees an all-zero channel.
    always_comb begin
        m0_r_valid = 1'b0;
        m0_r_data  = {DATA_WDTH{1'b0}};
        m0_r_resp  = {RESP_WDTH{1'b0}};
        m1_r_valid = 1'b0;
        m1_r_data  = {DATA_WDTH{1'b0}};
        m1_r_resp  = {RESP_WDTH{1'b0}};
        if (owner_s) begin
            m1_r_valid = own_r_valid_s;
            m1_r_data  = own_r_data_s;
            m1_r_resp  = own_r_resp_s;
        end else begin
            m0_r_valid = own_r_valid_s;
            m0_r_data  = own_r_data_s;
            m0_r_resp  = own_r_resp_s;
        end
    end

endmodule
